// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit word behind a 2-entry FIFO.
// Optional immediate/format checking is enabled by defining INSTR_ENCODER_IMM_CHECK_EN.
`default_nettype none

module instr_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic [15:0] enc_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0] word_q [0:1];
    logic        err_q  [0:1];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, rd_ptr_q;
    logic [15:0] enc_count_q;

    logic [31:0] word_d;
    logic        err_d;
    logic        push, pop;

    // Illegal formats 6/7 fall through to the R layout.
    always_comb begin
        word_d = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_I: word_d = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word_d = {imm[31:12], rd, opcode};
            FMT_J: word_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word_d = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    always_comb begin
        err_d = 1'b0;
        case (fmt)
            FMT_R:        err_d = 1'b0;
            FMT_I, FMT_S: err_d = (imm != {{20{imm[11]}}, imm[11:0]});
            FMT_B:        err_d = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            FMT_U:        err_d = (imm[11:0] != 12'd0);
            FMT_J:        err_d = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:      err_d = 1'b1;
        endcase
    end
`else
    always_comb begin
        err_d = 1'b0;
    end
`endif

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            enc_count_q <= 16'd0;
            word_q[0]   <= 32'd0;
            word_q[1]   <= 32'd0;
            err_q[0]    <= 1'b0;
            err_q[1]    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                word_q[wr_ptr_q] <= word_d;
                err_q[wr_ptr_q]  <= err_d;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q    <= ~rd_ptr_q;
                enc_count_q <= enc_count_q + 16'd1;
            end
        end
    end

    // Outputs come only from FIFO storage, gated to zero when empty.
    assign out_word  = out_valid ? word_q[rd_ptr_q] : 32'd0;
    assign out_err   = out_valid ? err_q[rd_ptr_q]  : 1'b0;
    assign enc_count = enc_count_q;

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  field bundle presented.
REQ-005 in_ready  output  1  block can accept a bundle.
REQ-006 fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-007 opcode  input  7  placed in word[6:0].
REQ-008 funct3  input  3; funct7  input  7; rs1, rs2, rd  input  5 each.
REQ-009 imm  input  32  full signed byte-offset or immediate value, unshifted.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer takes the word.
REQ-012 out_word  output  32  encoded RV32I instruction.
REQ-013 out_err  output  1  immediate or format error flag for out_word.
REQ-014 enc_count  output  16  count of words popped at the output.

Function
REQ-015 Encoding SHALL be as follows.
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-016 Encoding SHALL occur on acceptance; the block SHALL store {word, err} in a 2-entry FIFO.
REQ-017 Acceptance SHALL occur when in_valid and in_ready are both 1 at a rising edge; in_ready SHALL be 1 exactly when FIFO occupancy is less than 2.
REQ-018 out_valid SHALL be 1 exactly when occupancy is greater than 0; out_word and out_err SHALL show the oldest entry.
REQ-019 A pop SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-020 Latency: a bundle accepted at edge N into an empty FIFO SHALL appear on out_word after edge N with out_valid=1.
REQ-021 The output SHALL NOT combinationally depend on the inputs, and there SHALL be no bypass path.
REQ-022 Push and pop in the same edge at occupancy 1 SHALL leave occupancy at 1 and preserve order.
REQ-023 At occupancy 2, in_ready=0 and input is ignored; a pop at that edge SHALL NOT enable a same-edge push.
REQ-024 While out_valid=1 and out_ready=0, out_word and out_err SHALL remain stable.
REQ-025 enc_count SHALL increment by 1 per pop and wrap from 0xFFFF to 0x0000.
REQ-026 Read and write pointers SHALL be 1 bit each and wrap modulo 2.

Reset
REQ-027 Reset assertion SHALL immediately clear occupancy, pointers and enc_count, and SHALL discard words in flight.
REQ-028 While reset is asserted or when leaving reset: out_valid=0, in_ready=1, out_word=0, out_err=0, enc_count=0.
REQ-029 The first edge after reset_n rises SHALL be able to accept a bundle.

Configuration
REQ-030 Macro INSTR_ENCODER_IMM_CHECK_EN, when defined, SHALL set err for any of these conditions.
- fmt is 6 or 7.
- I or S: imm is not the sign-extension of imm[11:0].
- B: imm is not the sign-extension of imm[12:0], or imm[0]=1.
- U: imm[11:0] is nonzero.
- J: imm is not the sign-extension of imm[20:0], or imm[0]=1.
REQ-031 With the macro defined, an erroneous word SHALL still be encoded and queued as in REQ-015, with err=1.
REQ-032 When the macro is undefined, out_err SHALL be constant 0 and fmt 6/7 SHALL encode as R.

Verification
REQ-033 I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_word=0x00500093, err=0, one cycle later.
REQ-034 B, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463; U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-035 J, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF; J with imm=0x100000 and the macro defined -> err=1.
REQ-036 Three back-to-back bundles with out_ready=0 -> in_ready=0 after two accepts; third held; raising out_ready drains all three in order; enc_count=3.
REQ-037 Reset asserted mid-stream at occupancy 2 -> out_valid=0 immediately, enc_count=0, in_ready=1.
REQ-038 B with imm=3 -> err=1 with the macro defined, err=0 without it; the word is emitted in both cases.
